// File: rtl/counter_pkg.sv
// counter_pkg
// Shared definitions for the down_counter block: the two-state control FSM
// encoding and the all-ones value the counter and reload register take on
// reset. The reset constant is declared at a generous fixed width and sliced
// to the counter width N by its users.
package counter_pkg;

  // RUN: counting (or frozen with en=0). DONE: one-shot finished, parked at 0.
  typedef enum logic {
    ST_RUN  = 1'b0,
    ST_DONE = 1'b1
  } cnt_state_t;

  localparam int unsigned CNT_MAX_W = 32;

  // Reset value for q and rl; users take the low N bits.
  localparam logic [CNT_MAX_W-1:0] CNT_RESET_VAL = '1;

endpackage : counter_pkg

// File: rtl/down_count_next.sv
// down_count_next
// Next-count datapath for down_counter. Chooses between decrement, reload
// from the reload register and hold, and flags when a one-shot count has
// reached its end. Load is not handled here; the parent gives it priority.
//
// Ports
//   q_i        current count
//   rl_i       reload value used on wrap-around
//   state_i    current FSM state
//   en_i       count enable
//   mode_i     0 = periodic reload, 1 = one-shot stop
//   q_next_o   next count value when no load is present
//   to_done_o  1 when the FSM should move RUN -> DONE this edge
module down_count_next
  import counter_pkg::*;
#(
  parameter int N = 4
) (
  input  logic [N-1:0] q_i,
  input  logic [N-1:0] rl_i,
  input  cnt_state_t   state_i,
  input  logic         en_i,
  input  logic         mode_i,
  output logic [N-1:0] q_next_o,
  output logic         to_done_o
);

  localparam logic [N-1:0] ONE = {{(N-1){1'b0}}, 1'b1};

  logic q_zero;
  assign q_zero = (q_i == '0);

  always_comb begin
    q_next_o  = q_i;
    to_done_o = 1'b0;
    // Only an enabled RUN cycle moves the count; DONE always holds (at 0).
    if (state_i == ST_RUN && en_i) begin
      if (!q_zero) begin
        // Modulo 2^N; no borrow is needed because zero is handled below.
        q_next_o = q_i - ONE;
      end else if (mode_i) begin
        // One-shot: stay at 0 and park in DONE.
        to_done_o = 1'b1;
      end else begin
        // Periodic: wrap to the last loaded value.
        q_next_o = rl_i;
      end
    end
  end

endmodule : down_count_next

// File: rtl/down_counter.sv
// down_counter
// N-bit loadable down counter with periodic or one-shot terminal behaviour.
// Holds the count, reload and FSM state registers; the next-count selection
// lives in down_count_next.
//
// Ports
//   clk       clock, rising edge
//   rst       asynchronous active-high reset (q = rl = all ones, state RUN)
//   en        count enable; 0 freezes the counter
//   load      synchronous load strobe, overrides en
//   load_val  value captured into q and the reload register on load
//   mode      0 = periodic reload at zero, 1 = one-shot stop at zero
//   q         current count (registered)
//   tc        terminal count: RUN and q == 0
//   done      one-shot finished (state DONE)
module down_counter
  import counter_pkg::*;
#(
  parameter int N = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  input  logic         load,
  input  logic [N-1:0] load_val,
  input  logic         mode,
  output logic [N-1:0] q,
  output logic         tc,
  output logic         done
);

  localparam logic [N-1:0] RST_VAL = CNT_RESET_VAL[N-1:0];

  logic [N-1:0] q_q;
  logic [N-1:0] rl_q;
  cnt_state_t   state_q;

  logic [N-1:0] q_d;
  logic         to_done_d;

  down_count_next #(
    .N (N)
  ) u_next (
    .q_i       (q_d_src_q()),
    .rl_i      (rl_q),
    .state_i   (state_q),
    .en_i      (en),
    .mode_i    (mode),
    .q_next_o  (q_d),
    .to_done_o (to_done_d)
  );

  function automatic logic [N-1:0] q_d_src_q();
    return q_q;
  endfunction

  // Load wins over everything except reset; mode is only consulted by the
  // datapath at the RUN/en/zero edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q_q     <= RST_VAL;
      rl_q    <= RST_VAL;
      state_q <= ST_RUN;
    end else if (load) begin
      q_q     <= load_val;
      rl_q    <= load_val;
      state_q <= ST_RUN;
    end else begin
      q_q <= q_d;
      if (to_done_d) begin
        state_q <= ST_DONE;
      end
    end
  end

  // Outputs decode registers only; no input reaches them combinationally.
  assign q    = q_q;
  assign tc   = (state_q == ST_RUN) && (q_q == '0);
  assign done = (state_q == ST_DONE);

endmodule : down_counter

// File: tb/tb_down_counter.sv
// Testbench for down_counter (N = 4). A reference model predicts the
// registered outputs for each clock edge; predictions go into a scoreboard
// queue and are compared once the DUT has updated.
module tb_down_counter;

  localparam int N = 4;

  logic         clk;
  logic         rst;
  logic         en;
  logic         load;
  logic [N-1:0] load_val;
  logic         mode;
  logic [N-1:0] q;
  logic         tc;
  logic         done;

  down_counter #(.N(N)) dut (
    .clk      (clk),
    .rst      (rst),
    .en       (en),
    .load     (load),
    .load_val (load_val),
    .mode     (mode),
    .q        (q),
    .tc       (tc),
    .done     (done)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct packed {
    logic [N-1:0] q;
    logic         tc;
    logic         done;
  } exp_t;

  exp_t sb_q[$];

  int n_chk  = 0;
  int n_fail = 0;

  // Reference model state
  logic [N-1:0] m_q;
  logic [N-1:0] m_rl;
  logic         m_done;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_q    = '1;
    m_rl   = '1;
    m_done = 1'b0;
  endtask

  // Advance the model by one rising edge using the inputs now being driven.
  task automatic model_edge();
    exp_t e;
    if (load) begin
      m_q    = load_val;
      m_rl   = load_val;
      m_done = 1'b0;
    end else if (!m_done && en) begin
      if (m_q != 0)    m_q = m_q - 4'd1;
      else if (mode)   m_done = 1'b1;
      else             m_q = m_rl;
    end
    e.q    = m_q;
    e.tc   = !m_done && (m_q == 0);
    e.done = m_done;
    sb_q.push_back(e);
  endtask

  // One clock: predict, let the edge happen, then compare away from the edge.
  task automatic step(input string tag);
    exp_t e;
    model_edge();
    @(posedge clk);
    #1;
    if (sb_q.size() == 0) begin
      chk({tag, "_sb_empty"}, 32'd1, 32'd0);
    end else begin
      e = sb_q.pop_front();
      chk({tag, "_q"},    32'(q),    32'(e.q));
      chk({tag, "_tc"},   32'(tc),   32'(e.tc));
      chk({tag, "_done"}, 32'(done), 32'(e.done));
    end
  endtask

  task automatic drive(input logic l, input logic [N-1:0] lv, input logic e, input logic m);
    load = l; load_val = lv; en = e; mode = m;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    drive(1'b0, '0, 1'b0, 1'b0);
    rst = 1'b1;
    model_reset();
    #2;
    chk("rst_q", 32'(q), 32'd15);
    chk("rst_tc", 32'(tc), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;

    // Free-running count after reset, wrapping through 15.
    en = 1'b1;
    step("free_first");
    chk("free_first_14", 32'(q), 32'd14);
    for (int i = 0; i < 19; i++) step("free");
    chk("free_end_11", 32'(q), 32'd11);

    // One-shot from 5.
    drive(1'b1, 4'd5, 1'b0, 1'b1);
    step("os_load");
    load = 1'b0; en = 1'b1;
    for (int i = 0; i < 5; i++) step("os_cnt");
    chk("os_at0_tc", 32'(tc), 32'd1);
    step("os_enter");
    chk("os_done", 32'(done), 32'd1);
    for (int i = 0; i < 5; i++) begin
      mode = 1'(i);
      step("os_hold");
    end
    chk("os_hold_q", 32'(q), 32'd0);
    drive(1'b1, 4'd3, 1'b1, 1'b1);
    step("os_reload");
    chk("os_reload_q", 32'(q), 32'd3);

    // Load beats en; wrap uses the new reload value.
    drive(1'b1, 4'd4, 1'b0, 1'b0);
    step("lp_load4");
    drive(1'b0, 4'd0, 1'b1, 1'b0);
    step("lp_cnt");
    step("lp_cnt");
    drive(1'b1, 4'd9, 1'b1, 1'b0);
    step("lp_load9");
    chk("lp_q9", 32'(q), 32'd9);
    load = 1'b0;
    for (int i = 0; i < 10; i++) step("lp_wrap");
    chk("lp_wrap9", 32'(q), 32'd9);

    // Pause mid-count; mode toggles while not at zero have no effect.
    drive(1'b1, 4'd7, 1'b0, 1'b0);
    step("ps_load");
    load = 1'b0; en = 1'b1;
    for (int i = 0; i < 3; i++) step("ps_cnt");
    en = 1'b0;
    for (int i = 0; i < 4; i++) begin
      mode = ~mode;
      step("ps_hold");
    end
    chk("ps_hold4", 32'(q), 32'd4);
    en = 1'b1; mode = 1'b0;
    for (int i = 0; i < 5; i++) step("ps_resume");
    chk("ps_wrap7", 32'(q), 32'd7);

    // Async reset mid-count at q=6, then again in DONE.
    step("ar_cnt6");
    chk("ar_q6", 32'(q), 32'd6);
    #2 rst = 1'b1;
    #1;
    model_reset();
    chk("ar_mid_q", 32'(q), 32'd15);
    chk("ar_mid_tc", 32'(tc), 32'd0);
    #1 rst = 1'b0;
    drive(1'b1, 4'd5, 1'b0, 1'b1);
    step("ar_load5");
    load = 1'b0; en = 1'b1;
    for (int i = 0; i < 6; i++) step("ar_os");
    chk("ar_in_done", 32'(done), 32'd1);
    rst = 1'b1;
    #2;
    model_reset();
    chk("ar_done_done", 32'(done), 32'd0);
    chk("ar_done_q", 32'(q), 32'd15);
    #1 rst = 1'b0;

    // Zero load: periodic keeps tc high, then one-shot enters DONE.
    drive(1'b1, 4'd0, 1'b0, 1'b0);
    step("z_load");
    load = 1'b0; en = 1'b1;
    for (int i = 0; i < 5; i++) step("z_per");
    chk("z_per_tc", 32'(tc), 32'd1);
    mode = 1'b1;
    step("z_os");
    chk("z_os_done", 32'(done), 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule : tb_down_counter
